execute_scheduler: RTL and testbench
====================================

Name: execute_scheduler

Overview:
- Issue controller for the execute stage.
- Accepts decoded operations from decode over a valid/ready handshake and dispatches each one to the ALU (fixed latency 1) or the multiplier (latency MUL_LATENCY).
- Owns the single register-file writeback port through a writeback-slot reservation shift register.
- A 16-entry register scoreboard plus a CPSR pending bit stall dependent operations.

Parameters:
- MUL_LATENCY, 1, cycles from mul_go_o to a valid mul_result_i (1 to 4).
- RES_DEPTH, MUL_LATENCY+3, length of the writeback reservation vector.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low; the block is in reset while rst is 0.
- in_valid_i  in  1  decoded operation present.
- in_ready_o  out  1  scheduler accepts the operation this cycle.
- in_unit_i  in  1  0 = ALU, 1 = multiplier.
- in_long_i  in  1  64-bit multiply (SMULL/SMLAL/UMULL/UMLAL).
- in_dest_i  in  4  destination register; RdLo for long multiplies.
- in_dest_hi_i  in  4  RdHi; used only when in_long_i is 1.
- in_writes_dest_i  in  1  operation writes a register (0 for CMP/CMN/TST/TEQ).
- in_writes_cpsr_i  in  1  operation updates CPSR flags.
- in_reads_cpsr_i  in  1  operation consumes flags (ADC/SBC/RSC).
- in_src_mask_i  in  16  one-hot set of registers read.
- in_opcode_i  in  4  ALU opcode.
- in_type_i  in  3  multiplier type.
- alu_go_o  out  1  ALU operand strobe.
- alu_opcode_o  out  4  opcode to ALU.
- mul_go_o  out  1  multiplier operand strobe.
- mul_type_o  out  3  type to multiplier.
- alu_result_i  in  32  ALU result.
- mul_result_i  in  64  multiplier result.
- wb_valid_o  out  1  register or CPSR write this cycle.
- wb_dest_o  out  4  register written.
- wb_reg_o  out  1  the register write is enabled.
- wb_cpsr_o  out  1  the CPSR write is enabled (data on wb_data_o).
- wb_data_o  out  32  write data.
- busy_o  out  1  any operation in flight.

Behaviour:
Reset:
- All outputs, the scoreboard, the reservation vector and the multiplier-busy counter are 0.
- Reset asserted mid-operation discards all in-flight work; no writeback follows.

Handshake:
- Issue happens in cycle t when in_valid_i and in_ready_o are both 1.
- in_ready_o is combinational. It is 1 only when all of the following hold:
  - no register in in_src_mask_i is pending;
  - if in_writes_dest_i, in_dest_i is not pending (and in_dest_hi_i is not pending when long);
  - if in_reads_cpsr_i or in_writes_cpsr_i, the CPSR bit is not pending;
  - for multiplier ops, the multiplier is idle;
  - the required reservation slots are free.
- alu_go_o / mul_go_o, alu_opcode_o and mul_type_o are driven combinationally in the issue cycle.

Writeback slots (offsets from t):
- ALU: slot 2.
- Multiply: slot MUL_LATENCY+1.
- Long multiply: slots MUL_LATENCY+1 (RdLo, mul_result_i[31:0]) and MUL_LATENCY+2 (RdHi). The high word is latched internally in cycle t+MUL_LATENCY.
- The reservation vector shifts toward offset 0 every cycle. Each slot records source, dest, reg-enable and cpsr-enable.
- wb_* are registered. When the occupied slot reaches offset 1, the result is captured and wb_valid_o is 1 in the following cycle.

Scoreboard:
- Dest bits are set at issue and cleared in the cycle wb_valid_o is 1 for that dest.
- A same-cycle clear and a new issue to the same register resolves to set.
- The CPSR pending bit follows the same rule.

Multiplier busy:
- A counter loads MUL_LATENCY on mul_go_o and decrements to 0; the multiplier is idle at 0.

busy_o:
- 1 whenever the reservation vector or the counter is nonzero.

Data rules:
- No arithmetic happens in this block. wb_data_o is alu_result_i or a 32-bit half of mul_result_i.
- Compare ops write CPSR only: wb_reg_o = 0, wb_cpsr_o = 1.
- An operation with both write enables 0 still occupies its slot, with wb_valid_o = 0.

Decomposition:
- Shared package: unit select encodings, multiplier type codes (MUL, MLA, SMULL, SMLAL, UMULL, UMLAL), and the writeback slot record layout (valid, src, half, dest, reg_en, cpsr_en).
- Opcode constants come from the existing instruction definitions.
- One sub-module: execute_scoreboard (16+1 pending bits, set/clear ports, hazard check output).

Test Plan:
- ADD r1 issued at t=0 with ALU result 0x5 → wb_valid_o=1, wb_dest_o=1, wb_data_o=0x5 at t=2; in_ready_o stays 1 for back-to-back independent ALU ops.
- MUL r2 at t=0, then ADD r3,r2 at t=1 (MUL_LATENCY=1) → in_ready_o=0 at t=1; r2 is written at t=2; the ADD issues at t=2 and r3 is written at t=4.
- UMULL r4,r5 with a result of 0xFFFFFFFE_00000001 → r4=0x00000001 at t=2 and r5=0xFFFFFFFE at t=3; an independent ALU op offered at t=1 stalls one cycle (slot conflict).
- CMP followed by ADC → ADC stalls until the CPSR write (wb_cpsr_o=1, wb_reg_o=0) completes.
- MUL_LATENCY=3, two independent MULs back-to-back → the second issues at t=3.
- rst=0 asynchronously mid long multiply → all outputs are 0 immediately; after release, busy_o=0 and no stray writeback occurs.

Source files
------------

// File: rtl/execute_scheduler_pkg.sv
// rtl/execute_scheduler_pkg.sv - shared encodings and writeback slot layout for the execute scheduler
package execute_scheduler_pkg;

  typedef enum logic {
    UNIT_ALU = 1'b0,
    UNIT_MUL = 1'b1
  } unit_e;

  typedef enum logic [2:0] {
    MUL_T_MUL   = 3'b000,
    MUL_T_MLA   = 3'b001,
    MUL_T_UMULL = 3'b100,
    MUL_T_UMLAL = 3'b101,
    MUL_T_SMULL = 3'b110,
    MUL_T_SMLAL = 3'b111
  } mul_type_e;

  // Data-processing opcodes as encoded in the instruction word
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef struct packed {
    logic       valid;
    unit_e      src;
    logic       half;
    logic [3:0] dest;
    logic       reg_en;
    logic       cpsr_en;
  } wb_slot_t;

  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

endpackage

// File: rtl/execute_scoreboard.sv
// rtl/execute_scoreboard.sv - 16 register pending bits plus CPSR pending bit with hazard check
module execute_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] set_mask,
  input  logic        set_cpsr,
  input  logic [15:0] clr_mask,
  input  logic        clr_cpsr,
  input  logic [15:0] chk_mask,
  input  logic        chk_cpsr,
  output logic        hazard
);

  logic [15:0] pending;
  logic        cpsr_pending;

  // A writeback retiring this cycle no longer blocks a reader issuing in the same cycle
  always_comb begin
    hazard = (|(pending & ~clr_mask & chk_mask)) | (chk_cpsr & cpsr_pending & ~clr_cpsr);
  end

  // Set wins over a same-cycle clear of the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      cpsr_pending <= 1'b0;
    end else begin
      pending      <= (pending & ~clr_mask) | set_mask;
      cpsr_pending <= (cpsr_pending & ~clr_cpsr) | set_cpsr;
    end
  end

endmodule

// File: rtl/execute_scheduler.sv
// rtl/execute_scheduler.sv - execute-stage issue control with writeback slot reservation
module execute_scheduler
  import execute_scheduler_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int RES_DEPTH   = MUL_LATENCY + 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_unit_i,
  input  logic        in_long_i,
  input  logic [3:0]  in_dest_i,
  input  logic [3:0]  in_dest_hi_i,
  input  logic        in_writes_dest_i,
  input  logic        in_writes_cpsr_i,
  input  logic        in_reads_cpsr_i,
  input  logic [15:0] in_src_mask_i,
  input  logic [3:0]  in_opcode_i,
  input  logic [2:0]  in_type_i,
  output logic        alu_go_o,
  output logic [3:0]  alu_opcode_o,
  output logic        mul_go_o,
  output logic [2:0]  mul_type_o,
  input  logic [31:0] alu_result_i,
  input  logic [63:0] mul_result_i,
  output logic        wb_valid_o,
  output logic [3:0]  wb_dest_o,
  output logic        wb_reg_o,
  output logic        wb_cpsr_o,
  output logic [31:0] wb_data_o,
  output logic        busy_o
);

  // res[i] holds the slot whose offset is i+1 in the current cycle; res[0] is captured at the edge
  wb_slot_t    res   [RES_DEPTH];
  wb_slot_t    res_n [RES_DEPTH];
  wb_slot_t    head;
  logic [2:0]  mul_cnt;
  logic [31:0] hi_q;
  logic        is_mul, mul_idle, slot_free, hazard, issue, res_any;
  logic [15:0] dest_mask, clr_mask;

  assign is_mul    = (in_unit_i == UNIT_MUL);
  // The counter reaches zero at the next edge, so a new multiply may issue in its last busy cycle
  assign mul_idle  = (mul_cnt <= 3'd1);
  assign dest_mask = in_writes_dest_i ?
                     (reg_bit(in_dest_i) | (in_long_i ? reg_bit(in_dest_hi_i) : 16'h0)) : 16'h0;
  assign slot_free = is_mul ? (!res[MUL_LATENCY].valid && (!in_long_i || !res[MUL_LATENCY+1].valid))
                            : !res[1].valid;
  assign in_ready_o   = rst && !hazard && (!is_mul || mul_idle) && slot_free;
  assign issue        = in_valid_i && in_ready_o;
  assign alu_go_o     = issue && !is_mul;
  assign mul_go_o     = issue && is_mul;
  assign alu_opcode_o = alu_go_o ? in_opcode_i : 4'h0;
  assign mul_type_o   = mul_go_o ? in_type_i : 3'h0;
  assign clr_mask     = (wb_valid_o && wb_reg_o) ? reg_bit(wb_dest_o) : 16'h0;
  assign head         = res[0];
  assign busy_o       = res_any || (mul_cnt != 3'd0);

  execute_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_mask (issue ? dest_mask : 16'h0),
    .set_cpsr (issue && in_writes_cpsr_i),
    .clr_mask (clr_mask),
    .clr_cpsr (wb_valid_o && wb_cpsr_o),
    .chk_mask (in_src_mask_i | dest_mask),
    .chk_cpsr (in_reads_cpsr_i || in_writes_cpsr_i),
    .hazard   (hazard)
  );

  always_comb begin
    res_any = 1'b0;
    for (int i = 0; i < RES_DEPTH; i++) begin
      res_any = res_any | res[i].valid;
    end
    for (int i = 0; i < RES_DEPTH - 1; i++) begin
      res_n[i] = res[i+1];
    end
    res_n[RES_DEPTH-1] = '0;
    if (issue && !is_mul) begin
      res_n[0] = '{valid: 1'b1, src: UNIT_ALU, half: 1'b0, dest: in_dest_i,
                   reg_en: in_writes_dest_i, cpsr_en: in_writes_cpsr_i};
    end else if (issue) begin
      // Flags of a long multiply retire with the high word so CPSR stays pending until the end
      res_n[MUL_LATENCY-1] = '{valid: 1'b1, src: UNIT_MUL, half: 1'b0, dest: in_dest_i,
                               reg_en: in_writes_dest_i,
                               cpsr_en: in_writes_cpsr_i && !in_long_i};
      if (in_long_i) begin
        res_n[MUL_LATENCY] = '{valid: 1'b1, src: UNIT_MUL, half: 1'b1, dest: in_dest_hi_i,
                               reg_en: in_writes_dest_i, cpsr_en: in_writes_cpsr_i};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        res[i] <= '0;
      end
      mul_cnt    <= 3'd0;
      hi_q       <= 32'h0;
      wb_valid_o <= 1'b0;
      wb_dest_o  <= 4'h0;
      wb_reg_o   <= 1'b0;
      wb_cpsr_o  <= 1'b0;
      wb_data_o  <= 32'h0;
    end else begin
      res <= res_n;
      if (mul_go_o) begin
        mul_cnt <= 3'(MUL_LATENCY);
      end else if (mul_cnt != 3'd0) begin
        mul_cnt <= mul_cnt - 3'd1;
      end
      if (head.valid && head.src == UNIT_MUL && !head.half) begin
        hi_q <= mul_result_i[63:32];
      end
      wb_valid_o <= head.valid && (head.reg_en || head.cpsr_en);
      wb_dest_o  <= head.valid ? head.dest : 4'h0;
      wb_reg_o   <= head.valid && head.reg_en;
      wb_cpsr_o  <= head.valid && head.cpsr_en;
      if (!head.valid) begin
        wb_data_o <= 32'h0;
      end else if (head.src == UNIT_ALU) begin
        wb_data_o <= alu_result_i;
      end else begin
        wb_data_o <= head.half ? hi_q : mul_result_i[31:0];
      end
    end
  end

endmodule

// File: tb/tb_execute_scheduler.sv
// tb/tb_execute_scheduler.sv - directed bench for execute_scheduler
module tb_execute_scheduler;
  import execute_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_unit, in_long, in_wd, in_wc, in_rc;
  logic [3:0]  in_dest, in_dest_hi, in_opcode;
  logic [15:0] in_src;
  logic [2:0]  in_type;
  logic [31:0] alu_result;
  logic [63:0] mul_result;

  logic        in_ready, alu_go, mul_go, wb_valid, wb_reg, wb_cpsr, busy;
  logic [3:0]  alu_opcode, wb_dest;
  logic [2:0]  mul_type;
  logic [31:0] wb_data;

  logic        in_ready_3, alu_go_3, mul_go_3, wb_valid_3, wb_reg_3, wb_cpsr_3, busy_3;
  logic [3:0]  alu_opcode_3, wb_dest_3;
  logic [2:0]  mul_type_3;
  logic [31:0] wb_data_3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  execute_scheduler #(.MUL_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_unit_i(in_unit), .in_long_i(in_long), .in_dest_i(in_dest), .in_dest_hi_i(in_dest_hi),
    .in_writes_dest_i(in_wd), .in_writes_cpsr_i(in_wc), .in_reads_cpsr_i(in_rc),
    .in_src_mask_i(in_src), .in_opcode_i(in_opcode), .in_type_i(in_type),
    .alu_go_o(alu_go), .alu_opcode_o(alu_opcode), .mul_go_o(mul_go), .mul_type_o(mul_type),
    .alu_result_i(alu_result), .mul_result_i(mul_result),
    .wb_valid_o(wb_valid), .wb_dest_o(wb_dest), .wb_reg_o(wb_reg), .wb_cpsr_o(wb_cpsr),
    .wb_data_o(wb_data), .busy_o(busy)
  );

  execute_scheduler #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_3),
    .in_unit_i(in_unit), .in_long_i(in_long), .in_dest_i(in_dest), .in_dest_hi_i(in_dest_hi),
    .in_writes_dest_i(in_wd), .in_writes_cpsr_i(in_wc), .in_reads_cpsr_i(in_rc),
    .in_src_mask_i(in_src), .in_opcode_i(in_opcode), .in_type_i(in_type),
    .alu_go_o(alu_go_3), .alu_opcode_o(alu_opcode_3), .mul_go_o(mul_go_3), .mul_type_o(mul_type_3),
    .alu_result_i(alu_result), .mul_result_i(mul_result),
    .wb_valid_o(wb_valid_3), .wb_dest_o(wb_dest_3), .wb_reg_o(wb_reg_3), .wb_cpsr_o(wb_cpsr_3),
    .wb_data_o(wb_data_3), .busy_o(busy_3)
  );

  task automatic idle();
    in_valid = 0; in_unit = 0; in_long = 0; in_wd = 0; in_wc = 0; in_rc = 0;
    in_dest = 0; in_dest_hi = 0; in_opcode = 0; in_src = 0; in_type = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [3:0] d, input logic [15:0] src,
                        input logic wd, input logic wc, input logic rc);
    idle();
    in_valid = 1; in_unit = UNIT_ALU; in_opcode = op; in_dest = d; in_src = src;
    in_wd = wd; in_wc = wc; in_rc = rc;
  endtask

  task automatic mul_op(input logic [2:0] ty, input logic lng, input logic [3:0] d,
                        input logic [3:0] dh);
    idle();
    in_valid = 1; in_unit = UNIT_MUL; in_type = ty; in_long = lng;
    in_dest = d; in_dest_hi = dh; in_wd = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    next_cycle();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    alu_op(OP_ADD, 4'd1, 16'h0, 1, 0, 0);
    alu_result = 32'h0; mul_result = 64'h0;
    next_cycle();
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", in_ready); else passed++;
    checks++; if (alu_go !== 1'b0) $display("FAIL reset_alu_go got %b exp 0", alu_go); else passed++;
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) $display("FAIL reset_wb got %b/%h exp 0/0", wb_valid, wb_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    do_reset();
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    alu_op(OP_ADD, 4'd1, 16'h0001, 1, 0, 0); #1;
    checks++; if (in_ready !== 1'b1 || alu_go !== 1'b1) $display("FAIL add_issue got %b/%b exp 1/1", in_ready, alu_go); else passed++;
    checks++; if (alu_opcode !== OP_ADD) $display("FAIL add_opcode got %h exp %h", alu_opcode, OP_ADD); else passed++;
    next_cycle();
    alu_result = 32'h5;
    alu_op(OP_ADD, 4'd6, 16'h0080, 1, 0, 0); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", in_ready); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL add_busy got %b exp 1", busy); else passed++;
    next_cycle();
    idle(); alu_result = 32'h77;
    checks++; if ({wb_valid, wb_reg, wb_cpsr, wb_dest} !== {3'b110, 4'd1}) $display("FAIL add_wb got %b%b%b/%0d exp 110/1", wb_valid, wb_reg, wb_cpsr, wb_dest); else passed++;
    checks++; if (wb_data !== 32'h5) $display("FAIL add_data got %h exp 00000005", wb_data); else passed++;
    next_cycle();
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd6 || wb_data !== 32'h77) $display("FAIL add2_wb got %b/%0d/%h exp 1/6/00000077", wb_valid, wb_dest, wb_data); else passed++;
    next_cycle();
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_drain got %b/%b exp 0/0", wb_valid, busy); else passed++;
  endtask

  task automatic test_mul_raw();
    do_reset();
    mul_op(MUL_T_MUL, 0, 4'd2, 4'd0); #1;
    checks++; if (mul_go !== 1'b1 || mul_type !== MUL_T_MUL) $display("FAIL mul_go got %b/%h exp 1/0", mul_go, mul_type); else passed++;
    next_cycle();
    mul_result = 64'h0000_0000_0000_1234;
    alu_op(OP_ADD, 4'd3, 16'h0004, 1, 0, 0); #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL raw_stall got %b exp 0", in_ready); else passed++;
    next_cycle();
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd2 || wb_data !== 32'h1234) $display("FAIL mul_wb got %b/%0d/%h exp 1/2/00001234", wb_valid, wb_dest, wb_data); else passed++;
    checks++; if (in_ready !== 1'b1 || alu_go !== 1'b1) $display("FAIL raw_release got %b/%b exp 1/1", in_ready, alu_go); else passed++;
    next_cycle();
    idle(); alu_result = 32'h99;
    next_cycle();
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd3 || wb_data !== 32'h99) $display("FAIL raw_wb got %b/%0d/%h exp 1/3/00000099", wb_valid, wb_dest, wb_data); else passed++;
  endtask

  task automatic test_long_mul();
    do_reset();
    mul_op(MUL_T_UMULL, 1, 4'd4, 4'd5); #1;
    checks++; if (in_ready !== 1'b1 || mul_type !== MUL_T_UMULL) $display("FAIL umull_issue got %b/%h exp 1/4", in_ready, mul_type); else passed++;
    next_cycle();
    mul_result = 64'hFFFF_FFFE_0000_0001;
    alu_op(OP_MOV, 4'd8, 16'h0200, 1, 0, 0); #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL slot_conflict got %b exp 0", in_ready); else passed++;
    next_cycle();
    mul_result = 64'hDEAD_DEAD_DEAD_DEAD;
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd4 || wb_data !== 32'h1) $display("FAIL umull_lo got %b/%0d/%h exp 1/4/00000001", wb_valid, wb_dest, wb_data); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL slot_release got %b exp 1", in_ready); else passed++;
    next_cycle();
    idle(); alu_result = 32'h42;
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd5 || wb_data !== 32'hFFFF_FFFE) $display("FAIL umull_hi got %b/%0d/%h exp 1/5/fffffffe", wb_valid, wb_dest, wb_data); else passed++;
    next_cycle();
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd8 || wb_data !== 32'h42) $display("FAIL after_long got %b/%0d/%h exp 1/8/00000042", wb_valid, wb_dest, wb_data); else passed++;
  endtask

  task automatic test_cpsr();
    do_reset();
    alu_op(OP_CMP, 4'd0, 16'h0003, 0, 1, 0); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL cmp_issue got %b exp 1", in_ready); else passed++;
    next_cycle();
    alu_result = 32'h3;
    alu_op(OP_ADC, 4'd9, 16'h0002, 1, 0, 1); #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL adc_stall got %b exp 0", in_ready); else passed++;
    next_cycle();
    checks++; if ({wb_valid, wb_reg, wb_cpsr} !== 3'b101) $display("FAIL cmp_wb got %b%b%b exp 101", wb_valid, wb_reg, wb_cpsr); else passed++;
    checks++; if (in_ready !== 1'b1 || alu_opcode !== OP_ADC) $display("FAIL adc_release got %b/%h exp 1/5", in_ready, alu_opcode); else passed++;
    next_cycle();
    idle(); alu_result = 32'h11;
    next_cycle();
    checks++; if ({wb_valid, wb_reg, wb_cpsr} !== 3'b110 || wb_dest !== 4'd9) $display("FAIL adc_wb got %b%b%b/%0d exp 110/9", wb_valid, wb_reg, wb_cpsr, wb_dest); else passed++;
  endtask

  task automatic test_no_write();
    do_reset();
    alu_op(OP_TST, 4'd0, 16'h0001, 0, 0, 0);
    next_cycle();
    idle(); alu_result = 32'hAA;
    checks++; if (busy !== 1'b1) $display("FAIL nowrite_busy got %b exp 1", busy); else passed++;
    next_cycle();
    checks++; if (wb_valid !== 1'b0) $display("FAIL nowrite_wb got %b exp 0", wb_valid); else passed++;
  endtask

  task automatic test_mul_latency3();
    do_reset();
    mul_op(MUL_T_MUL, 0, 4'd1, 4'd0); #1;
    checks++; if (in_ready_3 !== 1'b1 || mul_go_3 !== 1'b1) $display("FAIL l3_first got %b/%b exp 1/1", in_ready_3, mul_go_3); else passed++;
    next_cycle();
    mul_op(MUL_T_MLA, 0, 4'd2, 4'd0); #1;
    checks++; if (in_ready_3 !== 1'b0) $display("FAIL l3_busy_t1 got %b exp 0", in_ready_3); else passed++;
    next_cycle();
    checks++; if (in_ready_3 !== 1'b0) $display("FAIL l3_busy_t2 got %b exp 0", in_ready_3); else passed++;
    next_cycle();
    mul_result = 64'h0000_0000_0000_0ABC;
    checks++; if (in_ready_3 !== 1'b1 || mul_type_3 !== MUL_T_MLA) $display("FAIL l3_second got %b/%h exp 1/1", in_ready_3, mul_type_3); else passed++;
    next_cycle();
    idle();
    checks++; if (wb_valid_3 !== 1'b1 || wb_dest_3 !== 4'd1 || wb_data_3 !== 32'hABC) $display("FAIL l3_wb1 got %b/%0d/%h exp 1/1/00000abc", wb_valid_3, wb_dest_3, wb_data_3); else passed++;
    next_cycle();
    next_cycle();
    mul_result = 64'h0000_0000_0000_0123;
    next_cycle();
    checks++; if (wb_valid_3 !== 1'b1 || wb_dest_3 !== 4'd2 || wb_data_3 !== 32'h123) $display("FAIL l3_wb2 got %b/%0d/%h exp 1/2/00000123", wb_valid_3, wb_dest_3, wb_data_3); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    mul_op(MUL_T_UMULL, 1, 4'd4, 4'd5);
    next_cycle();
    idle(); mul_result = 64'h1111_2222_3333_4444;
    next_cycle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h3333_4444) $display("FAIL pre_reset_wb got %b/%h exp 1/33334444", wb_valid, wb_data); else passed++;
    #2 rst = 0;
    alu_op(OP_ADD, 4'd1, 16'h0, 1, 0, 0);
    #1;
    checks++; if ({wb_valid, wb_reg, wb_dest, wb_data} !== 38'h0) $display("FAIL async_wb got %b/%b/%0d/%h exp 0/0/0/0", wb_valid, wb_reg, wb_dest, wb_data); else passed++;
    checks++; if ({in_ready, alu_go, busy} !== 3'b000) $display("FAIL async_ctrl got %b%b%b exp 000", in_ready, alu_go, busy); else passed++;
    idle();
    next_cycle();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset_%0d got %b/%b exp 0/0", i, wb_valid, busy); else passed++;
    end
  endtask

  initial begin
    idle();
    alu_result = 32'h0;
    mul_result = 64'h0;
    #1;
    test_reset();
    test_alu_back_to_back();
    test_mul_raw();
    test_long_mul();
    test_cpsr();
    test_no_write();
    test_mul_latency3();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
